// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial byte receive controller.
package serial_rx_pkg;

    // Frame sequencer states: waiting for START, or collecting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/shift_reg_en.sv
// LSB-first right-shift register: new bits enter at the MSB, so after WIDTH
// shifts the first bit received sits in bit 0.
module shift_reg_en
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over shifting so a frame restart never mixes in a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_byte_rx_ctrl.sv
// Frames strobed serial bits into DATA_WIDTH-bit words, enforces an
// inter-bit timeout and hands finished words to a single-entry output buffer.
//
// Output handshake: DATA_OUT is a word only while DATA_VALID is high, and it
// is held stable until the cycle in which DATA_VALID and DATA_READY are both
// high; that cycle's rising edge consumes it. A word finishing in that same
// cycle replaces it and DATA_VALID stays high.
module serial_byte_rx_ctrl
    import serial_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  START,
    input  logic                  BIT_STROBE,
    input  logic                  SERIAL_IN,
    input  logic                  DATA_READY,
    input  logic                  CLR_OVR,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    output logic                  BUSY,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN,
    output logic                  DBG_STATE
);

    localparam int BCW  = $clog2(DATA_WIDTH + 1);
    localparam int TCW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort happens on the cycle the idle count would reach the limit.
    localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    rx_state_t             state;
    logic [BCW-1:0]        bit_cnt;
    logic [TCW-1:0]        tmo_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  shift_en;
    logic                  last_bit;
    logic                  timeout_hit;
    logic                  can_load;
    logic                  shreg_lsb_unused;

    // A strobe only shifts inside a frame and never on a restart cycle.
    assign shift_en = (state == SHIFT) && BIT_STROBE && !START;

    shift_reg_en #(
        .WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk   (CLK),
        .rst_n (nRST),
        .en    (shift_en),
        .clr   (START),
        .din   (SERIAL_IN),
        .q     (shreg)
    );

    // The finished word is the post-shift value, taken directly so that it
    // can reach the buffer on the same edge as the final strobe.
    assign word_next        = {SERIAL_IN, shreg[DATA_WIDTH-1:1]};
    assign shreg_lsb_unused = shreg[0];

    assign last_bit    = shift_en && (bit_cnt == BCW'(DATA_WIDTH - 1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == SHIFT) && !START &&
                         !BIT_STROBE && (tmo_cnt == TCW'(TLIM));
    assign can_load    = !DATA_VALID || DATA_READY;

    assign BUSY      = (state == SHIFT);
    assign DBG_STATE = state;

    // Frame sequencer with its counters and all registered outputs; later
    // assignments win, so an overrun set beats a same-cycle clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            if (DATA_VALID && DATA_READY) begin
                DATA_VALID <= 1'b0;
            end
            if (CLR_OVR) begin
                OVERRUN <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (START) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (START) begin
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (BIT_STROBE) begin
                        tmo_cnt <= '0;
                        if (last_bit) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            if (can_load) begin
                                DATA_OUT   <= word_next;
                                DATA_VALID <= 1'b1;
                            end else begin
                                OVERRUN <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        tmo_cnt   <= '0;
                        FRAME_ERR <= 1'b1;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
